// File: rtl/sha256_stream_driver.sv
// Byte-stream front end for the serial SHA-256 core: buffers 64-byte blocks, inserts padding and
// the bit length, frames each block for the core and assembles the 64-nibble digest.
module sha256_stream_driver #(
  parameter int unsigned LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [7:0]   sha_data,
  output logic         sha_write_enable,
  output logic         sha_first_block,
  output logic         sha_last_block,
  input  logic         sha_busy,
  input  logic [3:0]   sha_digest,
  input  logic         sha_output_enable,
  output logic [255:0] m_digest,
  output logic         m_digest_valid,
  input  logic         m_digest_ready
);

  typedef enum logic [2:0] {StFill, StWait, StLaunch, StSend, StCollect, StHold} state_e;
  state_e state_q, state_d;

  logic [7:0]       buf_q [64];
  logic [6:0]       idx_q, r_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic             ended_q, pad80_done_q, first_pending_q, extra_pending_q;
  logic [5:0]       k_q, nib_q;
  logic [1:0]       guard_q;
  logic [255:0]     digest_q;
  logic             armed_q;

  logic        accept, last_in, final_blk, guard_clear, pad80_hit;
  logic [63:0] bit_len, len_shift;
  logic [7:0]  send_byte;

  assign accept      = s_valid && s_ready;
  assign last_in     = accept && (s_last || idx_q == 7'd63);
  // An appended length-only block runs with r=0 and ended=1, so it classifies as final too.
  assign final_blk   = ended_q && (r_q <= 7'd55);
  assign guard_clear = (guard_q == 2'd0);
  assign pad80_hit   = ({1'b0, k_q} == r_q) && ended_q && !pad80_done_q;
  assign bit_len     = 64'({byte_cnt_q, 3'b000});
  assign len_shift   = bit_len << {k_q[2:0], 3'b000};
  assign m_digest    = digest_q;

  always_comb begin
    send_byte = 8'h00;
    if ({1'b0, k_q} < r_q) begin
      send_byte = buf_q[k_q];
    end else if (pad80_hit) begin
      send_byte = 8'h80;
    end else if (final_blk && k_q >= 6'd56) begin
      send_byte = len_shift[63:56];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFill: begin
        if (last_in) state_d = (!sha_busy && guard_clear) ? StLaunch : StWait;
      end
      StWait:   if (!sha_busy && guard_clear) state_d = StLaunch;
      StLaunch: state_d = StSend;
      StSend: begin
        if (k_q == 6'd63) begin
          if (final_blk)            state_d = StCollect;
          else if (extra_pending_q) state_d = StWait;
          else                      state_d = StFill;
        end
      end
      StCollect: if (sha_output_enable && nib_q == 6'd63) state_d = StHold;
      StHold:    if (m_digest_ready) state_d = StFill;
      default:   state_d = StFill;
    endcase
  end

  always_comb begin
    s_ready          = 1'b0;
    sha_data         = 8'h00;
    sha_write_enable = 1'b0;
    sha_first_block  = 1'b0;
    sha_last_block   = 1'b0;
    m_digest_valid   = 1'b0;
    case (state_q)
      StFill:   s_ready = armed_q;
      StLaunch: sha_first_block = first_pending_q;
      StSend: begin
        sha_write_enable = 1'b1;
        sha_data         = send_byte;
        if (k_q == 6'd0) begin
          sha_first_block = first_pending_q;
          sha_last_block  = final_blk;
        end
      end
      StHold:  m_digest_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) buf_q[idx_q[5:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q           <= '0;
      r_q             <= '0;
      byte_cnt_q      <= '0;
      ended_q         <= 1'b0;
      pad80_done_q    <= 1'b0;
      first_pending_q <= 1'b1;
      extra_pending_q <= 1'b0;
      k_q             <= '0;
      nib_q           <= '0;
      guard_q         <= '0;
      digest_q        <= '0;
      armed_q         <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (!guard_clear) guard_q <= guard_q - 2'd1;
      case (state_q)
        StFill: begin
          if (accept) begin
            idx_q      <= idx_q + 7'd1;
            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
          end
          if (last_in) begin
            r_q             <= idx_q + 7'd1;
            ended_q         <= s_last;
            extra_pending_q <= s_last && (idx_q >= 7'd55);
          end
        end
        StSend: begin
          k_q <= k_q + 6'd1;
          if (pad80_hit) pad80_done_q <= 1'b1;
          if (k_q == 6'd63) begin
            first_pending_q <= 1'b0;
            guard_q         <= 2'd2;
            if (final_blk) begin
              nib_q <= '0;
            end else if (extra_pending_q) begin
              r_q             <= '0;
              extra_pending_q <= 1'b0;
            end else begin
              idx_q <= '0;
            end
          end
        end
        StCollect: begin
          if (sha_output_enable) begin
            digest_q <= {digest_q[251:0], sha_digest};
            nib_q    <= nib_q + 6'd1;
          end
        end
        StHold: begin
          if (m_digest_ready) begin
            idx_q           <= '0;
            r_q             <= '0;
            byte_cnt_q      <= '0;
            ended_q         <= 1'b0;
            pad80_done_q    <= 1'b0;
            extra_pending_q <= 1'b0;
            first_pending_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_driver.sv
// Directed bench for sha256_stream_driver; the bench plays the SHA core, capturing every byte the
// driver writes and returning a fixed digest nibble stream.
module tb_sha256_stream_driver;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [7:0]   sha_data;
  logic         sha_write_enable, sha_first_block, sha_last_block;
  logic         sha_busy = 1'b0;
  logic [3:0]   sha_digest = 4'h0;
  logic         sha_output_enable = 1'b0;
  logic [255:0] m_digest;
  logic         m_digest_valid;
  logic         m_digest_ready = 1'b0;

  localparam logic [255:0] AbcDigest =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] AltDigest =
    256'h0123456789abcdeffedcba987654321000112233445566778899aabbccddeeff;

  sha256_stream_driver #(.LEN_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .sha_data(sha_data), .sha_write_enable(sha_write_enable),
    .sha_first_block(sha_first_block), .sha_last_block(sha_last_block),
    .sha_busy(sha_busy), .sha_digest(sha_digest), .sha_output_enable(sha_output_enable),
    .m_digest(m_digest), .m_digest_valid(m_digest_valid), .m_digest_ready(m_digest_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap [1024];
  bit         cap_f [1024];
  bit         cap_l [1024];
  int         cap_cyc [1024];
  int         cap_n = 0;
  int         launch_n = 0;
  int         launch_cyc = -1;
  logic [7:0] eb [64];

  always @(negedge clk) begin
    if (sha_write_enable && cap_n < 1024) begin
      cap[cap_n]     = sha_data;
      cap_f[cap_n]   = sha_first_block;
      cap_l[cap_n]   = sha_last_block;
      cap_cyc[cap_n] = cyc;
      cap_n++;
    end
    if (sha_first_block && !sha_write_enable) begin
      launch_n++;
      launch_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input bit last, output int at);
    int n = 0;
    while (!s_ready && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $error("FAIL push_timeout: observed s_ready=0 expected s_ready=1");
    end
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    at      = cyc;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_msg(input int len, input logic [7:0] start, output int last_at);
    last_at = -1;
    for (int i = 0; i < len; i++) push(start + 8'(i), (i == len - 1), last_at);
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int w = 0;
    while (cap_n < n && w < 1000) begin
      step();
      w++;
    end
    chk({tag, " byte count"}, 256'(cap_n), 256'(n));
  endtask

  task automatic set_eb(input int n, input logic [7:0] start);
    for (int i = 0; i < 64; i++) eb[i] = (i < n) ? start + 8'(i) : 8'h00;
  endtask

  task automatic check_block(input string tag, input int base, input bit f, input bit l);
    int bad = -1;
    int late = 0;
    for (int i = 0; i < 64; i++) begin
      if (bad < 0 && cap[base+i] !== eb[i]) bad = i;
      if (i > 0 && (cap_f[base+i] || cap_l[base+i])) late++;
    end
    checks++;
    assert (bad == -1) else begin
      errors++;
      $error("FAIL %s bytes: byte %0d observed %0h expected %0h", tag, bad, cap[base+bad], eb[bad]);
    end
    chk({tag, " first/last at k=0"}, 256'({cap_f[base], cap_l[base]}), 256'({f, l}));
    chk({tag, " first/last after k=0"}, 256'(late), 256'(0));
  endtask

  // Core model: stream the digest nibbles, then check assembly, HOLD stability and release.
  task automatic finish_msg(input string tag, input logic [255:0] d, input int hold);
    int bad = 0;
    for (int i = 0; i < 64; i++) begin
      sha_output_enable = 1'b1;
      sha_digest        = d[255-4*i -: 4];
      step();
    end
    sha_output_enable = 1'b0;
    chk({tag, " digest valid"}, 256'(m_digest_valid), 256'(1));
    chk({tag, " digest"}, m_digest, d);
    for (int i = 0; i < hold; i++) begin
      step();
      if (!(m_digest_valid === 1'b1 && m_digest === d && s_ready === 1'b0)) bad++;
    end
    if (hold > 0) chk({tag, " hold stable"}, 256'(bad), 256'(0));
    m_digest_ready = 1'b1;
    step();
    m_digest_ready = 1'b0;
    chk({tag, " released"}, 256'({s_ready, m_digest_valid}), 256'(2'b10));
  endtask

  initial begin
    int base, t, x, ln0;

    #1 reset = 1'b1;
    step();
    step();
    chk("reset outputs", {s_ready, sha_data, sha_write_enable, sha_first_block, sha_last_block,
        m_digest_valid}, '0);
    chk("reset digest", m_digest, '0);
    reset = 1'b0;
    chk("s_ready before first edge", 256'(s_ready), 256'(0));
    step();
    chk("s_ready after first edge", 256'(s_ready), 256'(1));

    // "abc"
    base = cap_n;
    ln0  = launch_n;
    send_msg(3, 8'h61, t);
    wait_bytes("abc", base + 64);
    set_eb(3, 8'h61);
    eb[3]  = 8'h80;
    eb[63] = 8'h18;
    check_block("abc", base, 1'b1, 1'b1);
    chk("abc launch cycle", 256'(launch_cyc), 256'(t + 1));
    chk("abc k0 cycle", 256'(cap_cyc[base]), 256'(t + 2));
    chk("abc launch count", 256'(launch_n - ln0), 256'(1));
    finish_msg("abc", AbcDigest, 0);

    // 55 bytes: fits in one final block
    base = cap_n;
    send_msg(55, 8'h01, t);
    wait_bytes("len55", base + 64);
    set_eb(55, 8'h01);
    eb[55] = 8'h80;
    eb[62] = 8'h01;
    eb[63] = 8'hb8;
    check_block("len55", base, 1'b1, 1'b1);
    finish_msg("len55", AltDigest, 0);

    // 56 bytes: pad in block 1, length in block 2
    base = cap_n;
    ln0  = launch_n;
    send_msg(56, 8'h01, t);
    wait_bytes("len56", base + 128);
    set_eb(56, 8'h01);
    eb[56] = 8'h80;
    check_block("len56 b1", base, 1'b1, 1'b0);
    set_eb(0, 8'h00);
    eb[62] = 8'h01;
    eb[63] = 8'hc0;
    check_block("len56 b2", base + 64, 1'b0, 1'b1);
    chk("len56 launch count", 256'(launch_n - ln0), 256'(1));
    chk("len56 block gap>=4", 256'(cap_cyc[base+64] - cap_cyc[base+63] >= 4), 256'(1));
    finish_msg("len56", AltDigest, 0);

    // 64 bytes: 0x80 starts the extra block
    base = cap_n;
    send_msg(64, 8'ha0, t);
    wait_bytes("len64", base + 128);
    set_eb(64, 8'ha0);
    check_block("len64 b1", base, 1'b1, 1'b0);
    set_eb(0, 8'h00);
    eb[0]  = 8'h80;
    eb[62] = 8'h02;
    check_block("len64 b2", base + 64, 1'b0, 1'b1);
    finish_msg("len64", AltDigest, 0);

    // Core busy for 100 cycles, consumer stalls 10 cycles
    sha_busy = 1'b1;
    base = cap_n;
    send_msg(3, 8'h61, t);
    for (int i = 0; i < 100; i++) step();
    chk("busy no write", 256'(cap_n), 256'(base));
    sha_busy = 1'b0;
    x = cyc;
    wait_bytes("busy", base + 64);
    chk("busy launch cycle", 256'(launch_cyc), 256'(x + 1));
    set_eb(3, 8'h61);
    eb[3]  = 8'h80;
    eb[63] = 8'h18;
    check_block("busy abc", base, 1'b1, 1'b1);
    finish_msg("busy abc", AbcDigest, 10);

    // Reset in the middle of SEND, then a clean "abc"
    base = cap_n;
    send_msg(3, 8'h61, t);
    wait_bytes("abort", base + 20);
    chk("abort sending", 256'(sha_write_enable), 256'(1));
    reset = 1'b1;
    #1;
    chk("abort reset outputs", {s_ready, sha_data, sha_write_enable, sha_first_block,
        sha_last_block, m_digest_valid}, '0);
    chk("abort reset digest", m_digest, '0);
    step();
    step();
    reset = 1'b0;
    chk("abort s_ready low", 256'(s_ready), 256'(0));
    for (int i = 0; i < 5; i++) step();
    chk("abort no more writes", 256'(cap_n), 256'(base + 20));
    chk("abort s_ready up", 256'(s_ready), 256'(1));
    base = cap_n;
    send_msg(3, 8'h61, t);
    wait_bytes("post-reset abc", base + 64);
    check_block("post-reset abc", base, 1'b1, 1'b1);
    finish_msg("post-reset abc", AbcDigest, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_stream_driver.md
# sha256_stream_driver

Host-side initiator for the SHA-256 core's byte-serial interface. Accepts an arbitrary-length byte message over a valid/ready stream and buffers it 64 bytes at a time. Applies SHA-256 padding and the 64-bit big-endian length on the fly, and drives each block into the core with the core's write/first/last framing. It then collects the core's 64 serial digest nibbles into one 256-bit word and holds it for a downstream consumer.

## Interface
- LEN_W, 32, message byte-counter width; bit length = {byte_cnt, 3'b000}, zero-extended to 64 bits
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- s_data  in  8  message byte
- s_valid  in  1  s_data valid
- s_last  in  1  qualifies final byte of message (with s_valid)
- s_ready  out  1  driver accepts byte this cycle
- sha_data  out  8  byte to core
- sha_write_enable  out  1  sha_data valid
- sha_first_block  out  1  first-block marker
- sha_last_block  out  1  final-block marker
- sha_busy  in  1  core processing
- sha_digest  in  4  digest nibble, most significant first
- sha_output_enable  in  1  sha_digest valid
- m_digest  out  256  assembled digest, H0 in bits [255:224]
- m_digest_valid  out  1  m_digest valid
- m_digest_ready  in  1  consumer accepts digest

## Operation
- Storage: 64×8 block buffer; idx (7b, bytes in buffer); r (bytes of message in current block, 0..64); byte_cnt (LEN_W); flags ended, pad80_done, first_pending, extra_pending.
- FILL: s_ready=1. Each s_valid&s_ready writes buf[idx], idx++, byte_cnt++. Leave FILL for WAIT when the 64th byte is accepted or s_last is accepted; latch r=idx+1 and ended=s_last.
- Block classification: final = ended && r<=55; extra_pending set when ended && r>=56.
- WAIT: outputs idle; go to LAUNCH when sha_busy==0 and the guard counter is expired.
- LAUNCH (1 cycle): sha_first_block=first_pending, sha_write_enable=0.
- SEND (64 cycles, k=0..63): sha_write_enable=1; sha_first_block=first_pending and sha_last_block=final on k=0 only.
- SEND byte k, first matching rule:
  - k<r: buf[k].
  - k==r, ended, !pad80_done: 0x80 (sets pad80_done).
  - final and k>=56: bit-length byte k-56, MSB first.
  - otherwise: 0x00.
- After k=63: first_pending cleared.
  - Final block: go to COLLECT.
  - extra_pending: set r=0, final=1, clear extra_pending, go to WAIT. The extra block carries 0x80 at byte 0 only when the previous block had r=64.
  - Otherwise: clear idx, go to FILL.
- Guard: for 2 cycles after k=63, sha_busy is ignored and treated as busy.
- COLLECT: each cycle with sha_output_enable=1, shift m_digest left by 4 and insert sha_digest. After 64 nibbles go to HOLD.
- HOLD: m_digest_valid=1 and m_digest stable until m_digest_ready; then reset byte_cnt/flags, set first_pending=1, go to FILL.
- Empty messages are unsupported; every message has ≥1 byte carrying s_last.
- sha_output_enable outside COLLECT is ignored. s_ready=0 in every state except FILL.

## Timing
- Reset (async, any state): all outputs 0; m_digest=0; state FILL, first_pending=1, all counters 0. s_ready rises the first clock edge after reset deasserts.
- Reset mid-SEND/COLLECT: partial block/digest discarded; no further sha_write_enable until a new block fills.
- Block issue latency: last byte accepted at cycle t → LAUNCH at t+1 when sha_busy=0 → byte k on cycle t+2+k.
- sha_first_block is high on two consecutive cycles (LAUNCH, k=0) of the first block only.
- COLLECT completion: last nibble at cycle c → m_digest_valid at c+1.
- HOLD: m_digest_valid and m_digest_ready both high at cycle h → s_ready=1 at h+1.
- Back-to-back non-final blocks are spaced ≥3 cycles (guard + LAUNCH) after the previous k=63.

## Test plan
- "abc": s_data 61,62,63, s_last on 63 → one block: bytes 61 62 63 80, 52×00, then 00 00 00 00 00 00 00 18. first_block and last_block on k=0. m_digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad with the core model.
- 55-byte message → single final block: byte 55=0x80, bytes 56..63=00…01 B8.
- 56-byte message → two blocks:
  - block 1: byte 56=0x80, last_block=0.
  - block 2: first_block=0, last_block=1, bytes 0..55=00, bytes 56..63=00…01 C0.
- 64-byte message (s_last on byte 64) → second block byte 0=0x80, bytes 1..55=00, length 00…02 00.
- Backpressure:
  - sha_busy held high 100 cycles → no sha_write_enable; LAUNCH the cycle after sha_busy falls.
  - m_digest_ready low 10 cycles → m_digest/valid stable; s_ready stays 0.
- Reset asserted at k=20 → all outputs 0 immediately. Next message "abc" produces the correct digest with first_block set.
